// File: rtl/el2_trace_pkt_rdr.sv
// Captures retired-instruction trace packets into a small FIFO and streams each one out as 32-bit words.
// Optional build macro EL2_TRACE_TVAL_EN keeps per-entry tval storage and emits the TVAL word on traps.
module el2_trace_pkt_rdr #(
  parameter int TRACE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        trace_rv_i_valid_ip,
  input  logic [31:0] trace_rv_i_insn_ip,
  input  logic [31:0] trace_rv_i_address_ip,
  input  logic        trace_rv_i_exception_ip,
  input  logic [4:0]  trace_rv_i_ecause_ip,
  input  logic        trace_rv_i_interrupt_ip,
  input  logic [31:0] trace_rv_i_tval_ip,
  input  logic        trace_en,
  output logic        tr_word_valid,
  output logic [31:0] tr_word,
  output logic        tr_word_last,
  input  logic        tr_word_ready,
  output logic        trace_fifo_full,
  output logic [7:0]  trace_drop_cnt
);
  localparam int AW = $clog2(TRACE_DEPTH);

  typedef enum logic [2:0] {IDLE, HDR, ADDR, INSN, TVAL} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  seq_q, seq_d, drop_cnt_q, drop_cnt_d;
  logic        full_q, full_d;

  logic [31:0] insn_mem  [TRACE_DEPTH];
  logic [31:0] addr_mem  [TRACE_DEPTH];
  logic [6:0]  flags_mem [TRACE_DEPTH];
  logic [7:0]  seq_mem   [TRACE_DEPTH];
`ifdef EL2_TRACE_TVAL_EN
  logic [31:0] tval_mem  [TRACE_DEPTH];
`else
  logic        unused_tval;
  assign unused_tval = ^trace_rv_i_tval_ip;
`endif

  logic [AW-1:0] rd_idx, wr_idx;
  logic          empty, full, accept, final_pop, push, drop, hdr_acc, tval_present;
  logic [6:0]    h_flags;

  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign h_flags = flags_mem[rd_idx];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

`ifdef EL2_TRACE_TVAL_EN
  assign tval_present = h_flags[6] | h_flags[5];
`else
  assign tval_present = 1'b0;
`endif

  assign tr_word_valid = (state_q != IDLE);
  assign accept        = tr_word_valid & tr_word_ready;
  assign hdr_acc       = accept & (state_q == HDR);
  assign final_pop     = accept & (((state_q == INSN) & ~tval_present) | (state_q == TVAL));
  // A final-word pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push          = trace_rv_i_valid_ip & trace_en & (~full | final_pop);
  assign drop          = trace_rv_i_valid_ip & trace_en & full & ~final_pop;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, final_pop};
    seq_d      = push ? seq_q + 8'd1 : seq_q;
    drop_cnt_d = drop_cnt_q;
    if (hdr_acc) begin
      drop_cnt_d = {7'd0, drop};
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
    full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

    case (state_q)
      IDLE: if (wr_ptr_d != rd_ptr_d) state_d = HDR;
      HDR:  if (accept) state_d = ADDR;
      ADDR: if (accept) state_d = INSN;
      INSN: begin
        if (accept) begin
          if (tval_present)             state_d = TVAL;
          else if (wr_ptr_d != rd_ptr_d) state_d = HDR;
          else                          state_d = IDLE;
        end
      end
      TVAL: if (accept) state_d = (wr_ptr_d != rd_ptr_d) ? HDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tr_word      = 32'd0;
    tr_word_last = 1'b0;
    case (state_q)
      HDR:  tr_word = {seq_mem[rd_idx], drop_cnt_q, 7'd0, tval_present,
                       h_flags[6], h_flags[5], 1'b0, h_flags[4:0]};
      ADDR: tr_word = addr_mem[rd_idx];
      INSN: begin
        tr_word      = insn_mem[rd_idx];
        tr_word_last = ~tval_present;
      end
`ifdef EL2_TRACE_TVAL_EN
      TVAL: begin
        tr_word      = tval_mem[rd_idx];
        tr_word_last = 1'b1;
      end
`endif
      default: begin
        tr_word      = 32'd0;
        tr_word_last = 1'b0;
      end
    endcase
  end

  assign trace_fifo_full = full_q;
  assign trace_drop_cnt  = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      seq_q      <= 8'd0;
      drop_cnt_q <= 8'd0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
      full_q     <= full_d;
    end
  end

  // Storage needs no reset: pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      insn_mem[wr_idx]  <= trace_rv_i_insn_ip;
      addr_mem[wr_idx]  <= trace_rv_i_address_ip;
      flags_mem[wr_idx] <= {trace_rv_i_interrupt_ip, trace_rv_i_exception_ip, trace_rv_i_ecause_ip};
      seq_mem[wr_idx]   <= seq_q;
`ifdef EL2_TRACE_TVAL_EN
      tval_mem[wr_idx]  <= trace_rv_i_tval_ip;
`endif
    end
  end

endmodule

// File: tb/tb_el2_trace_pkt_rdr.sv
// Bench for el2_trace_pkt_rdr: packet-queue reference model checked every cycle, plus directed literal checks.
module tb_el2_trace_pkt_rdr;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        trace_rv_i_valid_ip = 1'b0;
  logic [31:0] trace_rv_i_insn_ip = '0;
  logic [31:0] trace_rv_i_address_ip = '0;
  logic        trace_rv_i_exception_ip = 1'b0;
  logic [4:0]  trace_rv_i_ecause_ip = '0;
  logic        trace_rv_i_interrupt_ip = 1'b0;
  logic [31:0] trace_rv_i_tval_ip = '0;
  logic        trace_en = 1'b1;
  logic        tr_word_valid;
  logic [31:0] tr_word;
  logic        tr_word_last;
  logic        tr_word_ready = 1'b0;
  logic        trace_fifo_full;
  logic [7:0]  trace_drop_cnt;

  always #5 clk = ~clk;

  el2_trace_pkt_rdr #(.TRACE_DEPTH(D)) dut (
    .clk(clk), .rst_l(rst_l),
    .trace_rv_i_valid_ip(trace_rv_i_valid_ip), .trace_rv_i_insn_ip(trace_rv_i_insn_ip),
    .trace_rv_i_address_ip(trace_rv_i_address_ip), .trace_rv_i_exception_ip(trace_rv_i_exception_ip),
    .trace_rv_i_ecause_ip(trace_rv_i_ecause_ip), .trace_rv_i_interrupt_ip(trace_rv_i_interrupt_ip),
    .trace_rv_i_tval_ip(trace_rv_i_tval_ip), .trace_en(trace_en),
    .tr_word_valid(tr_word_valid), .tr_word(tr_word), .tr_word_last(tr_word_last),
    .tr_word_ready(tr_word_ready), .trace_fifo_full(trace_fifo_full), .trace_drop_cnt(trace_drop_cnt)
  );

  typedef struct packed {
    logic [7:0]  seq;
    logic [31:0] insn;
    logic [31:0] addr;
    logic [31:0] tval;
    logic        exc;
    logic        intr;
    logic [4:0]  ec;
  } pkt_t;

  pkt_t mq[$];
  int   widx = 0;
  int   m_seq = 0;
  int   m_drop = 0;
  int   tests = 0;
  int   fails = 0;

  function automatic int nwords(pkt_t p);
`ifdef EL2_TRACE_TVAL_EN
    return (p.exc || p.intr) ? 4 : 3;
`else
    return 3;
`endif
  endfunction

  function automatic logic [31:0] word_of(pkt_t p, int idx, int drop);
    logic [31:0] w;
    case (idx)
      0: w = ({24'd0, p.seq} << 24) | (32'(drop) << 16) | ((nwords(p) == 4) ? 32'h100 : 32'h0)
             | (p.intr ? 32'h80 : 32'h0) | (p.exc ? 32'h40 : 32'h0) | {27'd0, p.ec};
      1: w = p.addr;
      2: w = p.insn;
      default: w = p.tval;
    endcase
    return w;
  endfunction

  function automatic pkt_t mk(logic [31:0] addr, logic [31:0] insn, logic exc, logic [4:0] ec,
                              logic intr, logic [31:0] tval);
    pkt_t p;
    p.seq = 8'd0; p.addr = addr; p.insn = insn; p.exc = exc; p.ec = ec; p.intr = intr; p.tval = tval;
    return p;
  endfunction

  function automatic pkt_t rnd_pkt();
    return mk($urandom, $urandom, ($urandom_range(0, 3) == 0), 5'($urandom), ($urandom_range(0, 5) == 0), $urandom);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(logic v, logic en, logic rdy, logic rst, pkt_t pin);
    bit   acc, fin, hdr, psh, drp;
    pkt_t p;
    if (rst) begin
      mq.delete(); widx = 0; m_seq = 0; m_drop = 0;
      return;
    end
    acc = (mq.size() > 0) && rdy;
    fin = acc && (widx == nwords(mq[0]) - 1);
    hdr = acc && (widx == 0);
    psh = v && en && ((mq.size() < D) || fin);
    drp = v && en && (mq.size() == D) && !fin;
    if (hdr) m_drop = drp ? 1 : 0;
    else if (drp && m_drop < 255) m_drop++;
    if (acc) begin
      widx++;
      if (fin) begin
        void'(mq.pop_front());
        widx = 0;
      end
    end
    if (psh) begin
      p = pin;
      p.seq = 8'(m_seq);
      mq.push_back(p);
      m_seq = (m_seq + 1) % 256;
    end
  endtask

  task automatic model_check();
    logic        ev, el;
    logic [31:0] ew;
    ev = (mq.size() > 0);
    ew = 32'd0;
    el = 1'b0;
    if (ev) begin
      ew = word_of(mq[0], widx, m_drop);
      el = (widx == nwords(mq[0]) - 1);
    end
    chk("m_valid", {31'd0, tr_word_valid}, {31'd0, ev});
    chk("m_word", tr_word, ew);
    chk("m_last", {31'd0, tr_word_last}, {31'd0, el});
    chk("m_full", {31'd0, trace_fifo_full}, {31'd0, (mq.size() == D)});
    chk("m_drop", {24'd0, trace_drop_cnt}, 32'(m_drop));
  endtask

  task automatic cyc(logic v, logic en, logic rdy, logic rst, pkt_t p);
    rst_l                   = ~rst;
    trace_rv_i_valid_ip     = v;
    trace_en                = en;
    tr_word_ready           = rdy;
    trace_rv_i_insn_ip      = p.insn;
    trace_rv_i_address_ip   = p.addr;
    trace_rv_i_exception_ip = p.exc;
    trace_rv_i_ecause_ip    = p.ec;
    trace_rv_i_interrupt_ip = p.intr;
    trace_rv_i_tval_ip      = p.tval;
    @(posedge clk);
    model_edge(v, en, rdy, rst, p);
    #1;
    model_check();
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0));
    cyc(1'b0, 1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0));
  endtask

  task automatic idle_cycles(int n, logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, rdy, 1'b0, mk(0, 0, 0, 0, 0, 0));
  endtask

  pkt_t zp;

  initial begin
    zp = mk(0, 0, 0, 0, 0, 0);

    // Reset state and a single plain packet
    do_reset();
    chk("rst_valid", {31'd0, tr_word_valid}, 32'd0);
    chk("rst_word", tr_word, 32'd0);
    chk("rst_full", {31'd0, trace_fifo_full}, 32'd0);
    chk("rst_drop", {24'd0, trace_drop_cnt}, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h0000_1000, 32'h0000_0013, 0, 0, 0, 0));
    chk("p1_hdr", tr_word, 32'h0000_0000);
    chk("p1_hdr_v", {31'd0, tr_word_valid}, 32'd1);
    chk("p1_hdr_last", {31'd0, tr_word_last}, 32'd0);
    idle_cycles(1, 1'b1);
    chk("p1_addr", tr_word, 32'h0000_1000);
    chk("p1_addr_last", {31'd0, tr_word_last}, 32'd0);
    idle_cycles(1, 1'b1);
    chk("p1_insn", tr_word, 32'h0000_0013);
    chk("p1_insn_last", {31'd0, tr_word_last}, 32'd1);
    idle_cycles(1, 1'b1);
    chk("p1_done", {31'd0, tr_word_valid}, 32'd0);
    $display("[TB] directed: single packet done");

    // Exception packet
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h0000_2000, 32'h0010_0073, 1, 5'd2, 0, 32'hDEAD_BEEF));
`ifdef EL2_TRACE_TVAL_EN
    chk("exc_hdr", tr_word, 32'h0000_0142);
`else
    chk("exc_hdr", tr_word, 32'h0000_0042);
`endif
    idle_cycles(2, 1'b1);
    chk("exc_insn", tr_word, 32'h0010_0073);
`ifdef EL2_TRACE_TVAL_EN
    chk("exc_insn_last", {31'd0, tr_word_last}, 32'd0);
    idle_cycles(1, 1'b1);
    chk("exc_tval", tr_word, 32'hDEAD_BEEF);
    chk("exc_tval_last", {31'd0, tr_word_last}, 32'd1);
`else
    chk("exc_insn_last", {31'd0, tr_word_last}, 32'd1);
`endif
    idle_cycles(1, 1'b1);
    chk("exc_done", {31'd0, tr_word_valid}, 32'd0);
    $display("[TB] directed: exception packet done");

    // Overflow with sink stalled
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h100 * i, 32'h13, 0, 0, 0, 0));
      if (i == 2) chk("ovf_not_full", {31'd0, trace_fifo_full}, 32'd0);
      if (i == 3) chk("ovf_full", {31'd0, trace_fifo_full}, 32'd1);
    end
    chk("ovf_drop", {24'd0, trace_drop_cnt}, 32'd2);
    chk("ovf_hdr0", tr_word, 32'h0002_0000);
    idle_cycles(1, 1'b1);
    chk("ovf_drop_clr", {24'd0, trace_drop_cnt}, 32'd0);
    idle_cycles(2, 1'b1);
    chk("ovf_hdr1", tr_word, 32'h0100_0000);
    idle_cycles(12, 1'b1);
    $display("[TB] directed: overflow done");

    // Push on the cycle the head's final word leaves a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h40 * i, 32'h13, 0, 0, 0, 0));
    idle_cycles(2, 1'b1);
    chk("fp_last", {31'd0, tr_word_last}, 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h500, 32'h13, 0, 0, 0, 0));
    chk("fp_nodrop", {24'd0, trace_drop_cnt}, 32'd0);
    chk("fp_full", {31'd0, trace_fifo_full}, 32'd1);
    chk("fp_valid", {31'd0, tr_word_valid}, 32'd1);
    chk("fp_hdr", tr_word, 32'h0100_0000);
    idle_cycles(20, 1'b1);
    $display("[TB] directed: full pass-through done");

    // Drop counter saturation, then drop in the HDR-accept cycle
    do_reset();
    for (int i = 0; i < D + 260; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, zp);
    chk("sat_drop", {24'd0, trace_drop_cnt}, 32'd255);
    chk("sat_hdr", tr_word, 32'h00FF_0000);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, zp);
    chk("sat_drop_one", {24'd0, trace_drop_cnt}, 32'd1);
    idle_cycles(20, 1'b1);
    $display("[TB] directed: drop saturation done");

    // Capture disabled
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, zp);
    chk("dis_valid", {31'd0, tr_word_valid}, 32'd0);
    chk("dis_drop", {24'd0, trace_drop_cnt}, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, zp);
    chk("dis_seq", tr_word >> 24, 32'd0);
    idle_cycles(4, 1'b1);
    $display("[TB] directed: capture disabled done");

    // Reset mid-packet
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h700, 32'h13, 0, 0, 0, 0));
    idle_cycles(2, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, zp);
    chk("mr_valid", {31'd0, tr_word_valid}, 32'd0);
    chk("mr_full", {31'd0, trace_fifo_full}, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, zp);
    chk("mr_valid2", {31'd0, tr_word_valid}, 32'd1);
    chk("mr_seq", tr_word >> 24, 32'd0);
    idle_cycles(4, 1'b1);
    $display("[TB] directed: mid-packet reset done");

    // Randomized traffic against the model
    begin
      int rdy_pct;
      int v_pct;
      rdy_pct = 70;
      v_pct = 60;
      for (int c = 0; c < 5000; c++) begin
        if (c % 250 == 0) begin
          rdy_pct = $urandom_range(5, 100);
          v_pct = $urandom_range(10, 100);
        end
        cyc($urandom_range(1, 100) <= v_pct, $urandom_range(1, 10) != 1,
            $urandom_range(1, 100) <= rdy_pct, $urandom_range(1, 600) == 1, rnd_pkt());
      end
      idle_cycles(30, 1'b1);
    end
    $display("[TB] random traffic done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/el2_trace_pkt_rdr.md
Name: el2_trace_pkt_rdr

Overview:
- Consumer end of the core's instruction-trace interface: the core drives one retired-instruction trace packet per cycle (valid, insn, address, exception, ecause, interrupt, tval).
- This block captures each valid packet into a FIFO and serializes it as 32-bit words over a valid/ready stream toward an off-core trace sink.
- Sits between the core's trace outputs and the SoC trace port.
- Counts packets dropped on overflow.

Parameters:
- TRACE_DEPTH, 4: FIFO depth in packets; power of 2, minimum 2.

Ports:
- clk  in  1  core clock
- rst_l  in  1  synchronous active-low reset
- trace_rv_i_valid_ip  in  1  trace packet valid
- trace_rv_i_insn_ip  in  32  instruction encoding
- trace_rv_i_address_ip  in  32  instruction PC
- trace_rv_i_exception_ip  in  1  exception flag
- trace_rv_i_ecause_ip  in  5  exception cause
- trace_rv_i_interrupt_ip  in  1  interrupt flag
- trace_rv_i_tval_ip  in  32  trap value
- trace_en  in  1  capture enable; when 0, valids are ignored and not counted as drops
- tr_word_valid  out  1  output word valid
- tr_word  out  32  output word
- tr_word_last  out  1  final word of the packet
- tr_word_ready  in  1  sink ready
- trace_fifo_full  out  1  FIFO holds TRACE_DEPTH packets
- trace_drop_cnt  out  8  running saturating drop count, not yet reported

Behaviour:
- Reset (rst_l=0 sampled at posedge):
  - FIFO emptied; FSM to IDLE; seq and drop counters cleared.
  - All outputs 0.
  - Applies mid-packet: a partially sent packet is abandoned.
- Push:
  - A push occurs when trace_rv_i_valid_ip & trace_en & (not full, or the final word of the head packet is accepted in the same cycle).
  - Each push stores insn, address, exc, ecause, intr, tval and seq[7:0].
  - seq increments on every push, wrapping 255 to 0.
- Drop:
  - valid & trace_en & full, with no same-cycle final pop, is a drop.
  - trace_drop_cnt increments and saturates at 255.
- Packet word order:
  - HDR, then ADDR (address), then INSN (insn), then TVAL (tval, only when exc|intr).
  - tr_word_last is 1 on the final word.
- HDR layout:
  - [31:24] seq
  - [23:16] drop count
  - [15:9] 0
  - [8] tval_present = exc|intr
  - [7] intr
  - [6] exc
  - [5] 0
  - [4:0] ecause
- Drop count in HDR:
  - Captured from trace_drop_cnt when HDR is accepted; the counter clears at that acceptance.
  - A drop in that same cycle leaves the counter at 1.
- FSM:
  - States: IDLE, HDR, ADDR, INSN, TVAL.
  - IDLE goes to HDR when the FIFO is non-empty.
  - Each state advances only on tr_word_valid & tr_word_ready.
  - INSN goes to TVAL if tval_present, otherwise pops the head.
  - TVAL pops the head.
  - After a pop: go to HDR if the FIFO is still non-empty (including a same-cycle push), otherwise IDLE.
  - No idle bubble occurs between back-to-back packets.
- Latency: a packet pushed at cycle t presents HDR at cycle t+1 at the earliest (registered storage, no bypass).
- Handshake:
  - Once tr_word_valid is asserted, it stays asserted until accepted, with tr_word and tr_word_last stable.
  - tr_word is 0 whenever tr_word_valid=0.
- Status: trace_fifo_full is registered and reflects occupancy == TRACE_DEPTH.
- Pointers: read and write pointers carry log2(TRACE_DEPTH)+1 bits; full/empty are decoded from the MSB compare; pointers wrap.

Optional Feature:
- Macro: EL2_TRACE_TVAL_EN.
- Defined: tval is stored per entry and the TVAL word is emitted as above.
- Undefined:
  - tval storage is removed (entry width drops by 32).
  - HDR[8] is forced to 0.
  - Every packet is exactly 3 words, with INSN last.
  - trace_rv_i_tval_ip is unused.

Test Plan:
- Reset, then a single push with address=0x0000_1000, insn=0x0000_0013, no exception, ready=1 → words 0x0000_0000, 0x0000_1000, 0x0000_0013 on cycles t+1..t+3; last is 1 on the third word only.
- Push with exc=1, ecause=2, tval=0xDEAD_BEEF (EL2_TRACE_TVAL_EN defined) → HDR=0x0000_0142, 4 words, last on 0xDEAD_BEEF. With the macro undefined → HDR=0x0000_0042, 3 words.
- Hold ready=0 and push 6 packets with TRACE_DEPTH=4 → trace_fifo_full=1 after the 4th, trace_drop_cnt=2. Then ready=1 → first HDR = 0x0002_0000, 2nd HDR = 0x0100_0000, counter 0.
- Full FIFO, push on the same cycle the final word of the head packet is accepted → push accepted, no drop, HDR of the next packet follows with no idle cycle.
- trace_en=0 with 3 valids → no words, trace_drop_cnt=0, seq unchanged. Next enabled push has HDR[31:24]=0x00.
- Assert rst_l=0 after the ADDR word of a packet → next cycle tr_word_valid=0, FIFO empty. The next push emits HDR with seq=0x00.
